uart_rx_fifo: RTL

Receive-side buffer directly downstream of uart_rx; consumes its rx_valid/rx_out pair and stores each received byte in a first-word-fall-through FIFO. Provides a valid/ready-style pop interface to the consumer (CPU bus or command parser). Also provides a sticky overrun flag, an almost-full level, and an idle-line timeout pulse so the consumer can drain partial packets.

---
 rtl/uart_rx_fifo_pkg.sv | 18 +
 rtl/uart_rx_fifo_sync_fifo.sv | 57 +++++
 rtl/uart_rx_fifo.sv | 89 ++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants and divider helpers, kept common with uart_rx/uart_tx.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FRAME_BITS = 10;
  localparam int UART_OVERSAMPLE = 16;

  // Oversample tick divider, integer division exactly as uart_rx computes it.
  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / (baud_rate * UART_OVERSAMPLE);
  endfunction

  // Clock cycles spanned by a number of idle character times.
  function automatic int timeout_cyc(input int chars, input int clk_freq, input int baud_rate);
    return chars * UART_FRAME_BITS * UART_OVERSAMPLE * baud_div(clk_freq, baud_rate);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO: storage, pointers and occupancy.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             rd_ok;
  logic             wr_ok;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign rd_valid = ~empty;
  // A pop frees the slot on the same edge, so a full FIFO still accepts a write.
  assign rd_ok    = rd_en & ~empty;
  assign wr_ok    = wr_en & (~full | rd_ok);
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  // Storage write; data is never reset, only the pointers qualify it.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: edge-captured bytes into a FWFT FIFO, with
// sticky overrun, almost-full level and an idle-line timeout pulse.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BAUD_RATE     = 9600,
  parameter int DEPTH         = 16,
  parameter int AF_LEVEL      = 12,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [UART_DATA_W-1:0]   rx_data,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [UART_DATA_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full,
  output logic                     overrun,
  input  logic                     overrun_clr,
  output logic                     idle_timeout
);

  localparam int CW          = $clog2(DEPTH) + 1;
  localparam int TIMEOUT_CYC = timeout_cyc(TIMEOUT_CHARS, CLK_FREQ, BAUD_RATE);
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);

  logic          rx_valid_q;
  logic          push;
  logic          pop;
  logic          full;
  logic          drop;
  logic          next_empty;
  logic [TW-1:0] timer;

  // Timer advance that parks at the terminal value instead of wrapping.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v < TW'(TIMEOUT_CYC)) ? v + TW'(1) : v;
  endfunction

  assign push        = rx_valid & ~rx_valid_q;
  assign pop         = rd_en & rd_valid;
  assign drop        = push & full & ~pop;
  // Occupancy will be zero after this edge (a push always clears the timer anyway).
  assign next_empty  = ~push & (~rd_valid | (pop & (count == CW'(1))));
  assign almost_full = (count >= CW'(AF_LEVEL));

  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (push),
    .wr_data  (rx_data),
    .rd_en    (rd_en),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full)
  );

  // rx_valid history for edge detect; resets high so a level held through reset is ignored.
  always_ff @(posedge clk) begin
    if (reset) rx_valid_q <= 1'b1;
    else       rx_valid_q <= rx_valid;
  end

  // Sticky overrun; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset)            overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

  // Idle timer: restarts on any push or when the FIFO drains, pulses once on reaching the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer        <= '0;
      idle_timeout <= 1'b0;
    end else begin
      timer        <= (push | next_empty) ? '0 : sat_inc(timer);
      idle_timeout <= ~push & ~next_empty & (timer == TW'(TIMEOUT_CYC - 1));
    end
  end

endmodule
